// File: rtl/canvas_port_arbiter.sv
// canvas_port_arbiter
//   Owns the single-port canvas RGB memory behind the paint display and
//   arbitrates one access per cycle between three requesters:
//     display read (highest) > clear sweep write > brush write.
//   Every access chosen in cycle T appears on the registered mem_* outputs
//   at T+1. Display data returns on disp_rgb/disp_valid exactly 3 cycles
//   after the pix_en request.
//
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   pix_en, DrawX, DrawY  display pixel request (screen coordinates)
//   disp_rgb, disp_valid  display result, 3-cycle latency
//   brush_*               canvas-relative brush write, req/ack handshake
//   clear_req, clear_rgb  start a full-canvas sweep with the given colour
//   busy, clear_done      sweep in progress / end-of-sweep pulse
//   mem_addr/we/wdata     registered memory command
//   mem_rdata             synchronous read data (one cycle after mem_addr)

module canvas_port_arbiter #(
    parameter int CANVAS_X0 = 100,
    parameter int CANVAS_Y0 = 100,
    parameter int CANVAS_W  = 440,
    parameter int CANVAS_H  = 280,
    parameter int ADDR_W    = 17
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pix_en,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [23:0]       disp_rgb,
    output logic              disp_valid,
    input  logic              brush_req,
    input  logic [8:0]        brush_x,
    input  logic [8:0]        brush_y,
    input  logic [23:0]       brush_rgb,
    output logic              brush_ack,
    input  logic              clear_req,
    input  logic [23:0]       clear_rgb,
    output logic              busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [23:0]       mem_wdata,
    input  logic [23:0]       mem_rdata
);

    // Sweep states. FINISH is the one cycle after the last clear write has
    // reached the memory port; the sweep only reports done after that.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CLEAR  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [9:0]        X_LO      = 10'(CANVAS_X0);
    localparam logic [9:0]        X_HI      = 10'(CANVAS_X0 + CANVAS_W);
    localparam logic [9:0]        Y_LO      = 10'(CANVAS_Y0);
    localparam logic [9:0]        Y_HI      = 10'(CANVAS_Y0 + CANVAS_H);
    localparam logic [8:0]        BRUSH_W   = 9'(CANVAS_W);
    localparam logic [8:0]        BRUSH_H   = 9'(CANVAS_H);
    localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(CANVAS_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CANVAS_W * CANVAS_H - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [23:0]       clr_rgb_q, clr_rgb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ack_q, ack_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [23:0]       mem_wdata_q, mem_wdata_d;
    // vld_pipe[0]: request registered (T+1), [1]: data on mem_rdata (T+2),
    // [2]: result on disp_rgb (T+3). hit_pipe tracks in-canvas for [0],[1].
    logic [2:0]        vld_pipe_q, vld_pipe_d;
    logic [1:0]        hit_pipe_q, hit_pipe_d;
    logic [23:0]       disp_rgb_q, disp_rgb_d;

    logic              pix_hit;
    logic              brush_in;
    logic              brush_grant;
    logic [9:0]        disp_dx, disp_dy;
    logic [ADDR_W-1:0] disp_addr, brush_addr;

    assign pix_hit = pix_en && (DrawX >= X_LO) && (DrawX < X_HI)
                            && (DrawY >= Y_LO) && (DrawY < Y_HI);
    assign disp_dx   = DrawX - X_LO;
    assign disp_dy   = DrawY - Y_LO;
    assign disp_addr = ADDR_W'(disp_dy) * ROW_PITCH + ADDR_W'(disp_dx);

    assign brush_in   = (brush_x < BRUSH_W) && (brush_y < BRUSH_H);
    assign brush_addr = ADDR_W'(brush_y) * ROW_PITCH + ADDR_W'(brush_x);

    // A pending clear_req takes the idle slot, and a request still visible
    // during its own ack cycle is not granted a second time.
    assign brush_grant = (state_q == S_IDLE) && brush_req && !pix_hit
                         && !clear_req && !ack_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_rgb_d   = clr_rgb_q;
        done_d      = 1'b0;
        ack_d       = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d   = S_CLEAR;
                    cnt_d     = '0;
                    clr_rgb_d = clear_rgb;
                end
            end
            S_CLEAR: begin
                if (!pix_hit) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == LAST_ADDR) state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Port mux: a display read owns the slot; otherwise the sweep, then
        // the brush. Out-of-range brush requests are acked without a write.
        if (pix_hit) begin
            mem_addr_d = disp_addr;
        end else if (state_q == S_CLEAR) begin
            mem_addr_d  = cnt_q;
            mem_we_d    = 1'b1;
            mem_wdata_d = clr_rgb_q;
        end else if (brush_grant) begin
            ack_d = 1'b1;
            if (brush_in) begin
                mem_addr_d  = brush_addr;
                mem_we_d    = 1'b1;
                mem_wdata_d = brush_rgb;
            end
        end

        busy_d = (state_d != S_IDLE);

        vld_pipe_d = {vld_pipe_q[1:0], pix_en};
        hit_pipe_d = {hit_pipe_q[0], pix_hit};
        disp_rgb_d = disp_rgb_q;
        if (vld_pipe_q[1]) disp_rgb_d = hit_pipe_q[1] ? mem_rdata : 24'h0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            clr_rgb_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            vld_pipe_q  <= '0;
            hit_pipe_q  <= '0;
            disp_rgb_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clr_rgb_q   <= clr_rgb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ack_q       <= ack_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            vld_pipe_q  <= vld_pipe_d;
            hit_pipe_q  <= hit_pipe_d;
            disp_rgb_q  <= disp_rgb_d;
        end
    end

    assign disp_rgb   = disp_rgb_q;
    assign disp_valid = vld_pipe_q[2];
    assign brush_ack  = ack_q;
    assign busy       = busy_q;
    assign clear_done = done_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
